// File: rtl/traffic_intersection.sv
// traffic_intersection
//   Multi-approach intersection controller. It cycles through
//   GREEN -> YELLOW -> ALLRED for one approach at a time, with optional WALK.
//   The next approach is picked by demand-driven round-robin over car_present.
//   The current approach gets green again only if it is the only requester.
//   If no approach is requesting, the controller steps to the next approach.
//
//   Optional feature: define TRAFFIC_PED_EN to compile in the pedestrian WALK
//   phase, the ped_pending latch and the walk lamp. Without it, ped_req is
//   ignored and walk is held at 0.
//
// Ports
//   clk          rising-edge clock
//   rstb         asynchronous active-high reset
//   car_present  [NUM_DIR]   per-approach vehicle sensor
//   ped_req      pedestrian button (any pulse >= 1 cycle)
//   light        [2*NUM_DIR] lamp pair per approach: 00 red, 01 green, 10 yellow
//   active_dir   approach owning green/yellow (last owner during all-red/walk)
//   walk         pedestrian walk lamp
module traffic_intersection #(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [NUM_DIR-1:0]         car_present,
    input  logic                       ped_req,
    output logic [2*NUM_DIR-1:0]       light,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       walk
);

    localparam int DW   = $clog2(NUM_DIR);
    localparam int M1   = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
    localparam int M2   = (ALLRED_CYC > WALK_CYC) ? ALLRED_CYC : WALK_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

`ifdef TRAFFIC_PED_EN
    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, WALK} state_t;
`else
    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   dir_n, sel_dir, idx;
    logic [2*NUM_DIR-1:0] light_n;
    logic            walk_n;
    logic            found;

    // Round-robin search starting after the current owner. The owner is
    // checked last, so it keeps green only when no other approach requests.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        sel_dir = DW'((int'(active_dir) + 1) % NUM_DIR);
        for (int k = 1; k <= NUM_DIR; k++) begin
            idx = DW'((int'(active_dir) + k) % NUM_DIR);
            if (!found && car_present[idx]) begin
                found   = 1'b1;
                sel_dir = idx;
            end
        end
    end

`ifdef TRAFFIC_PED_EN
    logic ped_pending;
`endif

    // Next state. cnt counts up from 0, and each phase ends when cnt reaches its length minus 1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        dir_n   = active_dir;
        case (state)
            GREEN: if (cnt == CW'(GREEN_CYC - 1)) begin
                state_n = YELLOW;
                cnt_n   = '0;
            end
            YELLOW: if (cnt == CW'(YELLOW_CYC - 1)) begin
                state_n = ALLRED;
                cnt_n   = '0;
            end
            ALLRED: if (cnt == CW'(ALLRED_CYC - 1)) begin
                cnt_n = '0;
`ifdef TRAFFIC_PED_EN
                if (ped_pending) begin
                    state_n = WALK;
                end else begin
                    state_n = GREEN;
                    dir_n   = sel_dir;
                end
`else
                state_n = GREEN;
                dir_n   = sel_dir;
`endif
            end
`ifdef TRAFFIC_PED_EN
            WALK: if (cnt == CW'(WALK_CYC - 1)) begin
                state_n = GREEN;
                cnt_n   = '0;
                dir_n   = sel_dir;
            end
`endif
            default: begin
                state_n = GREEN;
                cnt_n   = '0;
            end
        endcase
    end

    // Lamps are decoded from the next state and registered.
    // This makes a phase change appear on the outputs in the cycle the phase is entered.
    always_comb begin
        light_n = '0;
        walk_n  = 1'b0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (DW'(i) == dir_n) begin
                if (state_n == GREEN)  light_n[2*i +: 2] = 2'b01;
                if (state_n == YELLOW) light_n[2*i +: 2] = 2'b10;
            end
        end
`ifdef TRAFFIC_PED_EN
        walk_n = (state_n == WALK);
`endif
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state      <= GREEN;
            cnt        <= '0;
            active_dir <= '0;
            light      <= {{(2*NUM_DIR-2){1'b0}}, 2'b01};
            walk       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            active_dir <= dir_n;
            light      <= light_n;
            walk       <= walk_n;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Clearing on WALK entry takes priority over a press in that same cycle.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            ped_pending <= 1'b0;
        else if (state_n == WALK && state != WALK)
            ped_pending <= 1'b0;
        else if (ped_req && state != WALK)
            ped_pending <= 1'b1;
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req;
`endif

endmodule

// File: tb/tb_traffic_intersection.sv
// Bench for traffic_intersection with NUM_DIR=4, G=4, Y=2, A=1, W=3.
// The driver pushes the expected outputs for each cycle into a queue.
// A monitor pops those entries on the falling edge and compares them with the DUT outputs.
module tb_traffic_intersection;
    localparam int G = 4, Y = 2, A = 1, W = 3;

    logic       clk = 0;
    logic       rstb;
    logic [3:0] car_present;
    logic       ped_req;
    logic [7:0] light;
    logic [1:0] active_dir;
    logic       walk;

    traffic_intersection #(.NUM_DIR(4), .GREEN_CYC(G), .YELLOW_CYC(Y),
                           .ALLRED_CYC(A), .WALK_CYC(W)) dut (
        .clk(clk), .rstb(rstb), .car_present(car_present), .ped_req(ped_req),
        .light(light), .active_dir(active_dir), .walk(walk));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] light;
        logic [1:0] dir;
        logic       walk;
    } exp_t;

    typedef struct {
        logic [3:0] car;  // sensor value held through the period
        logic [1:0] dir;  // approach expected to be served in that period
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    function automatic exp_t mk(input int ph, input logic [1:0] d, input logic w);
        exp_t e;
        e.light = (ph == 1) ? (8'b01 << (2*d)) : (ph == 2) ? (8'b10 << (2*d)) : 8'b0;
        e.dir   = d;
        e.walk  = w;
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({light, active_dir, walk} !== e) begin
                failures++;
                $display("FAIL seq cyc=%0d got light=%b dir=%0d walk=%b exp light=%b dir=%0d walk=%b",
                         cyc, light, active_dir, walk, e.light, e.dir, e.walk);
            end
        end
    end

    task automatic chk(input string nm, input exp_t e);
        checks++;
        if ({light, active_dir, walk} !== e) begin
            failures++;
            $display("FAIL %s got light=%b dir=%0d walk=%b exp light=%b dir=%0d walk=%b",
                     nm, light, active_dir, walk, e.light, e.dir, e.walk);
        end
    endtask

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_period(input logic [1:0] d, input logic [3:0] c, input bit ped_first);
        car_present = c;
        for (int i = 0; i < G; i++) begin
            ped_req = (i == 0) && ped_first;
            step(mk(1, d, 1'b0));
            ped_req = 1'b0;
        end
        for (int i = 0; i < Y; i++) step(mk(2, d, 1'b0));
        for (int i = 0; i < A; i++) step(mk(0, d, 1'b0));
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b1001, 2'd0};
        tbl[1]  = '{4'b1001, 2'd3};
        tbl[2]  = '{4'b1001, 2'd0};
        tbl[3]  = '{4'b0000, 2'd3};
        tbl[4]  = '{4'b0000, 2'd0};
        tbl[5]  = '{4'b0000, 2'd1};
        tbl[6]  = '{4'b0000, 2'd2};
        tbl[7]  = '{4'b0100, 2'd3};
        tbl[8]  = '{4'b0100, 2'd2};
        tbl[9]  = '{4'b1111, 2'd2};
        tbl[10] = '{4'b0010, 2'd3};
        tbl[11] = '{4'b0000, 2'd1};

        rstb = 1'b1;
        car_present = '0;
        ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", mk(1, 2'd0, 1'b0));
        rstb = 1'b0;

        // Served order comes from the table, so the lamp and direction checks cover the selection logic.
        for (int i = 0; i < 12; i++)
            run_period(tbl[i].dir, tbl[i].car, 1'b0);

        // A pedestrian press during green causes one walk after all-red.
        // A press during walk is ignored.
        run_period(2'd2, 4'b0000, 1'b1);
`ifdef TRAFFIC_PED_EN
        for (int i = 0; i < W; i++) begin
            ped_req = (i == 0);
            step(mk(0, 2'd2, 1'b1));
            ped_req = 1'b0;
        end
`endif
        run_period(2'd3, 4'b0100, 1'b0);

        // Reset in the middle of yellow for approach 2 also drops a pending request.
        car_present = 4'b0000;
        for (int i = 0; i < G; i++) begin
            ped_req = (i == 0);
            step(mk(1, 2'd2, 1'b0));
            ped_req = 1'b0;
        end
        step(mk(2, 2'd2, 1'b0));
        rstb = 1'b1;
        #1;
        chk("async_reset", mk(1, 2'd0, 1'b0));
        @(posedge clk);
        #1;
        chk("reset_hold", mk(1, 2'd0, 1'b0));
        rstb = 1'b0;
        run_period(2'd0, 4'b0000, 1'b0);
        step(mk(1, 2'd1, 1'b0));

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
